// File: rtl/bram_read_arbiter.sv
// Two-requester round-robin arbiter over one read-only BRAM port. Handles one transaction at a time:
// 3 cycles from accept to response in range, 1 cycle out of range. Stalled requests and held responses are never dropped.
module bram_read_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_BYTES = 65536
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  rq0_valid,
  input  logic [ADDR_WIDTH-1:0] rq0_addr,
  output logic                  rq0_ready,
  input  logic                  rq1_valid,
  input  logic [ADDR_WIDTH-1:0] rq1_addr,
  output logic                  rq1_ready,
  output logic                  rs0_valid,
  output logic [DATA_WIDTH-1:0] rs0_data,
  output logic                  rs0_err,
  input  logic                  rs0_ready,
  output logic                  rs1_valid,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic                  rs1_err,
  input  logic                  rs1_ready,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic [15:0]           contention_cnt
);

  localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hDEADBEEF);

  typedef enum logic [1:0] {IDLE, READ, CAPTURE, RESP} state_t;

  state_t                  state, state_nxt;
  logic                    owner;
  logic                    rr_ptr;
  logic [ADDR_WIDTH-3:0]   addr_q;
  logic [1:0]              rs_valid_q;
  logic [1:0]              rs_err_q;
  logic [DATA_WIDTH-1:0]   rs_data_q [0:1];

  logic                    gnt1;
  logic                    accept;
  logic                    resp_done;
  logic                    busy;
  logic                    contend;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    req_oor;
  logic [1:0]              rs_ready_v;

  // rr_ptr=1 means requester 1 wins a tie
  assign gnt1       = rq1_valid & (~rq0_valid | rr_ptr);
  assign req_addr   = gnt1 ? rq1_addr : rq0_addr;
  assign req_oor    = 32'(req_addr) >= DEPTH_BYTES;
  assign rs_ready_v = {rs1_ready, rs0_ready};
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rq0_ready = 1'b0;
    rq1_ready = 1'b0;
    bram_en   = 1'b0;
    bram_addr = '0;
    accept    = 1'b0;
    resp_done = 1'b0;
    case (state)
      IDLE: begin
        if (resetn) begin
          rq0_ready = rq0_valid & ~gnt1;
          rq1_ready = gnt1;
        end
        accept = rq0_ready | rq1_ready;
        if (accept) state_nxt = req_oor ? RESP : READ;
      end
      READ: begin
        bram_en   = 1'b1;
        bram_addr = {addr_q, 2'b00};
        state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = RESP;
      RESP: begin
        resp_done = rs_ready_v[owner];
        if (resp_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A refused requester counts only when the other side is the reason it waits
  assign contend = (rq0_valid & ~rq0_ready & (rq1_ready | (busy &  owner)))
                 | (rq1_valid & ~rq1_ready & (rq0_ready | (busy & ~owner)));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      owner          <= 1'b0;
      rr_ptr         <= 1'b0;
      addr_q         <= '0;
      rs_valid_q     <= '0;
      rs_err_q       <= '0;
      rs_data_q[0]   <= '0;
      rs_data_q[1]   <= '0;
      contention_cnt <= '0;
    end else begin
      if (accept) begin
        owner  <= gnt1;
        rr_ptr <= ~gnt1;
        addr_q <= req_addr[ADDR_WIDTH-1:2];
        if (req_oor) begin
          rs_valid_q[gnt1] <= 1'b1;
          rs_err_q[gnt1]   <= 1'b1;
          rs_data_q[gnt1]  <= ERR_DATA;
        end
      end
      if (state == CAPTURE) begin
        rs_valid_q[owner] <= 1'b1;
        rs_err_q[owner]   <= 1'b0;
        rs_data_q[owner]  <= bram_dout;
      end
      if (resp_done) rs_valid_q[owner] <= 1'b0;
      if (contend && contention_cnt != 16'hFFFF)
        contention_cnt <= contention_cnt + 16'd1;
    end
  end

  assign rs0_valid = rs_valid_q[0];
  assign rs1_valid = rs_valid_q[1];
  assign rs0_err   = rs_err_q[0];
  assign rs1_err   = rs_err_q[1];
  assign rs0_data  = rs_data_q[0];
  assign rs1_data  = rs_data_q[1];

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Directed bench for bram_read_arbiter with a one-cycle-latency BRAM model and 4 KiB address space.
module tb_bram_read_arbiter;

  logic        clk;
  logic        resetn;
  logic        rq0_valid, rq1_valid;
  logic [15:0] rq0_addr, rq1_addr;
  logic        rq0_ready, rq1_ready;
  logic        rs0_valid, rs1_valid;
  logic [31:0] rs0_data, rs1_data;
  logic        rs0_err, rs1_err;
  logic        rs0_ready, rs1_ready;
  logic        bram_en;
  logic [15:0] bram_addr;
  logic [31:0] bram_dout;
  logic [15:0] contention_cnt;

  logic [31:0] mem [0:1023];
  int          checks = 0;
  int          errors = 0;

  bram_read_arbiter #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (32),
    .DEPTH_BYTES(32'h1000)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .rq0_valid     (rq0_valid),
    .rq0_addr      (rq0_addr),
    .rq0_ready     (rq0_ready),
    .rq1_valid     (rq1_valid),
    .rq1_addr      (rq1_addr),
    .rq1_ready     (rq1_ready),
    .rs0_valid     (rs0_valid),
    .rs0_data      (rs0_data),
    .rs0_err       (rs0_err),
    .rs0_ready     (rs0_ready),
    .rs1_valid     (rs1_valid),
    .rs1_data      (rs1_data),
    .rs1_err       (rs1_err),
    .rs1_ready     (rs1_ready),
    .bram_en       (bram_en),
    .bram_addr     (bram_addr),
    .bram_dout     (bram_dout),
    .contention_cnt(contention_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (bram_en) bram_dout <= mem[bram_addr[11:2]];

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | i;
    mem[1] = 32'h1234_5678;
    bram_dout = '0;
    resetn = 1'b0;
    rq0_valid = 1'b1; rq0_addr = '0;
    rq1_valid = 1'b0; rq1_addr = '0;
    rs0_ready = 1'b0; rs1_ready = 1'b0;

    // reset state, ready held low even with a valid request
    step(3);
    chk("rst_rq0_ready", rq0_ready, 0);
    chk("rst_rs0_valid", rs0_valid, 0);
    chk("rst_rs1_valid", rs1_valid, 0);
    chk("rst_bram_en", bram_en, 0);
    chk("rst_bram_addr", bram_addr, 0);
    chk("rst_cnt", contention_cnt, 0);
    chk("rst_rs0_data", rs0_data, 0);
    chk("rst_rs1_err", rs1_err, 0);
    rq0_valid = 1'b0;
    resetn = 1'b1;
    step(1);

    // single in-range read
    rq0_valid = 1'b1; rq0_addr = 16'h0006;
    #1 chk("t1_rq0_ready", rq0_ready, 1);
    step(1);
    rq0_valid = 1'b0;
    chk("t1_read_en", bram_en, 1);
    chk("t1_read_addr", bram_addr, 16'h0004);
    step(1);
    chk("t1_cap_en", bram_en, 0);
    chk("t1_cap_valid", rs0_valid, 0);
    step(1);
    chk("t1_resp_valid", rs0_valid, 1);
    chk("t1_resp_data", rs0_data, 32'h1234_5678);
    chk("t1_resp_err", rs0_err, 0);
    chk("t1_rs1_valid", rs1_valid, 0);
    rs0_ready = 1'b1;
    step(1);
    chk("t1_done_valid", rs0_valid, 0);

    // simultaneous requests from reset
    resetn = 1'b0;
    step(1);
    resetn = 1'b1;
    rs0_ready = 1'b1; rs1_ready = 1'b1;
    rq0_valid = 1'b1; rq0_addr = 16'h0010;
    rq1_valid = 1'b1; rq1_addr = 16'h0020;
    #1 chk("t2_tie_rq0_ready", rq0_ready, 1);
    chk("t2_tie_rq1_ready", rq1_ready, 0);
    step(1);
    rq0_valid = 1'b0;
    step(2);
    chk("t2_rs0_valid", rs0_valid, 1);
    chk("t2_rs0_data", rs0_data, mem[4]);
    step(1);
    chk("t2_rq1_ready", rq1_ready, 1);
    chk("t2_cnt4", contention_cnt, 4);
    step(1);
    rq1_valid = 1'b0;
    step(2);
    chk("t2_rs1_valid", rs1_valid, 1);
    chk("t2_rs1_data", rs1_data, mem[8]);
    step(1);
    rq0_valid = 1'b1; rq1_valid = 1'b1;
    #1 chk("t2_rr_rq0_ready", rq0_ready, 1);
    chk("t2_rr_rq1_ready", rq1_ready, 0);
    step(1);
    rq0_valid = 1'b0; rq1_valid = 1'b0;
    chk("t2_cnt5", contention_cnt, 5);
    step(2);
    chk("t2_rs0_valid2", rs0_valid, 1);
    step(1);
    chk("t2_rs0_done", rs0_valid, 0);

    // out-of-range read
    rs1_ready = 1'b0;
    rq1_valid = 1'b1; rq1_addr = 16'h1000;
    #1 chk("t3_rq1_ready", rq1_ready, 1);
    step(1);
    rq1_valid = 1'b0;
    chk("t3_rs1_valid", rs1_valid, 1);
    chk("t3_rs1_err", rs1_err, 1);
    chk("t3_rs1_data", rs1_data, 32'hDEAD_BEEF);
    chk("t3_bram_en", bram_en, 0);
    chk("t3_rs0_valid", rs0_valid, 0);
    rs1_ready = 1'b1;
    step(1);
    chk("t3_done", rs1_valid, 0);

    // backpressure on rs0 while rq1 waits; rs1_ready from the non-owner is ignored
    rs0_ready = 1'b0;
    rq0_valid = 1'b1; rq0_addr = 16'h000C;
    #1 chk("t4_rq0_ready", rq0_ready, 1);
    step(1);
    rq0_valid = 1'b0;
    rq1_valid = 1'b1; rq1_addr = 16'h0014;
    #1 chk("t4_rq1_stall_read", rq1_ready, 0);
    step(2);
    chk("t4_rs0_valid", rs0_valid, 1);
    chk("t4_rs0_data", rs0_data, mem[3]);
    chk("t4_rs1_data_kept", rs1_data, 32'hDEAD_BEEF);
    chk("t4_rs1_err_kept", rs1_err, 1);
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("t4_hold_valid", rs0_valid, 1);
      chk("t4_hold_data", rs0_data, mem[3]);
      chk("t4_hold_rq1", rq1_ready, 0);
    end
    rs0_ready = 1'b1;
    #1 chk("t4_rq1_hs_cycle", rq1_ready, 0);
    step(1);
    rs0_ready = 1'b0;
    #1 chk("t4_rs0_released", rs0_valid, 0);
    chk("t4_rq1_granted", rq1_ready, 1);
    step(1);
    rq1_valid = 1'b0;
    chk("t4_rq1_en", bram_en, 1);
    chk("t4_rq1_addr", bram_addr, 16'h0014);
    step(2);
    chk("t4_rs1_valid", rs1_valid, 1);
    chk("t4_rs1_data", rs1_data, mem[5]);
    chk("t4_rs1_err", rs1_err, 0);
    step(1);
    chk("t4_rs1_done", rs1_valid, 0);

    // reset while in READ abandons the transaction
    rs0_ready = 1'b1;
    rq0_valid = 1'b1; rq0_addr = 16'h0008;
    step(1);
    rq0_valid = 1'b0;
    chk("t5_in_read", bram_en, 1);
    resetn = 1'b0;
    step(1);
    chk("t5_en", bram_en, 0);
    chk("t5_addr", bram_addr, 0);
    chk("t5_rs0_valid", rs0_valid, 0);
    chk("t5_rs0_data", rs0_data, 0);
    chk("t5_rs1_data", rs1_data, 0);
    chk("t5_rs1_err", rs1_err, 0);
    chk("t5_cnt", contention_cnt, 0);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t5_no_resp", {rs1_valid, rs0_valid, bram_en}, 0);
    end

    // contention counter saturation
    rs0_ready = 1'b0;
    rq0_valid = 1'b1; rq0_addr = 16'h0000;
    rq1_valid = 1'b1; rq1_addr = 16'h0004;
    step(1);
    rq0_valid = 1'b0;
    step(99);
    chk("t6_cnt100", contention_cnt, 100);
    step(69900);
    chk("t6_cnt_sat", contention_cnt, 16'hFFFF);
    step(20);
    chk("t6_cnt_nowrap", contention_cnt, 16'hFFFF);
    rq1_valid = 1'b0;
    rs0_ready = 1'b1;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
